wback_regfile: RTL

//  Y86-64 write-back stage plus architectural register file. Consumes W_* from the M->W pipeline

---
 rtl/wback_regfile_if.sv | 42 ++++
 rtl/wback_regfile.sv | 108 ++++++++++
 2 files changed

// File: rtl/wback_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : wback_regfile_if
//  Purpose  : Bundles the M->W pipeline register fields, the two decode read
//             ports and the committed status/counter outputs of the Y86-64
//             write-back/register-file block.
//  Signals  : W_stat[2], W_icode[4], W_valE[XLEN], W_valM[XLEN],
//             W_dstE[4], W_dstM[4], d_srcA[4], d_srcB[4]   (master -> slave)
//             d_rvalA[XLEN], d_rvalB[XLEN], Stat[2], halted,
//             retired[CNT_W]                               (slave -> master)
//  Modports : master (pipeline / bench side), slave (register file side)
//  Revision : 1.0  initial release
// ============================================================================
interface wback_regfile_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
);
  logic [1:0]       W_stat;
  logic [3:0]       W_icode;
  logic [XLEN-1:0]  W_valE;
  logic [XLEN-1:0]  W_valM;
  logic [3:0]       W_dstE;
  logic [3:0]       W_dstM;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [XLEN-1:0]  d_rvalA;
  logic [XLEN-1:0]  d_rvalB;
  logic [1:0]       Stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, Stat, halted, retired
  );

  modport slave (
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, Stat, halted, retired
  );
endinterface
`default_nettype wire

// File: rtl/wback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wback_regfile
//  Purpose  : Y86-64 write-back stage and architectural register file.
//             Commits W_valE/W_valM into the 15 program registers, serves two
//             combinational decode read ports, latches the sticky processor
//             status and counts retired instructions.
//  Ports    : clk    - pipeline clock, all state updates on rising edge
//             reset  - asynchronous, active-high, clears all state
//             bus    - wback_regfile_if.slave (W_* inputs, decode read ports,
//                      Stat / halted / retired outputs)
//  Revision : 1.0  initial release
// ============================================================================
module wback_regfile #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RSP_RESET = '0,
  parameter int              CNT_W     = 64
) (
  input  wire logic          clk,
  input  wire logic          reset,
  wback_regfile_if.slave     bus
);

  localparam logic [3:0] RNONE     = 4'hF;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [1:0] STAT_AOK  = 2'd0;
  localparam logic [1:0] STAT_HLT  = 2'd1;
  localparam int         NREGS     = 15;
  localparam int         RSP_ID    = 4;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            state_q,   state_d;
  logic [1:0]        stat_q,    stat_d;
  logic              halted_q,  halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [XLEN-1:0]   regs_q [0:NREGS-1];
  logic [XLEN-1:0]   regs_d [0:NREGS-1];
  logic              count_en;
  logic [XLEN-1:0]   rval_a, rval_b;

  // HLT retires (it is the last instruction of the program); ADR/INS faults
  // and bubbles do not.
  assign count_en = ((bus.W_stat == STAT_AOK) && (bus.W_icode != ICODE_NOP)) ||
                    (bus.W_stat == STAT_HLT);

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    regs_d    = regs_q;
    if (state_q == ST_RUN) begin
      stat_d = bus.W_stat;
      if (bus.W_stat != STAT_AOK) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
      if (count_en) begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // M port is applied after E so that valM wins a same-register conflict.
      if (bus.W_stat == STAT_AOK) begin
        if (bus.W_dstE != RNONE) regs_d[bus.W_dstE] = bus.W_valE;
        if (bus.W_dstM != RNONE) regs_d[bus.W_dstM] = bus.W_valM;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      stat_q    <= STAT_AOK;
      halted_q  <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == RSP_ID) ? RSP_RESET : '0;
      end
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads see the array as it stands; same-cycle W values are not bypassed.
  always_comb begin
    rval_a = '0;
    rval_b = '0;
    if (bus.d_srcA != RNONE) rval_a = regs_q[bus.d_srcA];
    if (bus.d_srcB != RNONE) rval_b = regs_q[bus.d_srcB];
  end

  assign bus.d_rvalA = rval_a;
  assign bus.d_rvalB = rval_b;
  assign bus.Stat    = stat_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule
`default_nettype wire
